// File: rtl/simd_alu_pipe.sv
// ----------------------------------------------------------------------------
// simd_alu_pipe
//
// Purpose:
//   Lane-parallel integer ALU for the execute stage. Both XLEN-wide operands
//   are split into LANES equal lanes of LW = XLEN/LANES bits. The same opcode
//   is applied to every lane independently, with no carry between lanes.
//   ADD and SUB can optionally saturate on signed overflow. The result then
//   passes through PIPE_STAGES register stages that use valid/ready
//   backpressure. The unit supports a flush, and it keeps a sticky flag that
//   records saturation.
//
// Ports:
//   clk_i, rst_i           clock; synchronous active-high reset
//   flush_i                drop every in-flight op at the next edge
//   in_valid_i/in_ready_o  input handshake
//   op_i, sat_i            opcode and saturation enable (ADD/SUB only)
//   operand_a_i/_b_i       packed lanes, lane k = bits [k*LW +: LW]
//   trans_id_i             tag that travels with the op
//   out_valid_o/out_ready_i output handshake
//   result_o, trans_id_o   packed lane results and their tag
//   sat_o                  at least one lane of this result saturated
//   sat_sticky_o           OR of sat_o over every accepted result since the
//                          last clear
//   sat_clr_i              clear sat_sticky_o; takes priority over a set
//                          in the same cycle
// ----------------------------------------------------------------------------
module simd_alu_pipe #(
  parameter int XLEN        = 64,
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TRANS_ID_W  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            op_i,
  input  logic                  sat_i,
  input  logic [XLEN-1:0]       operand_a_i,
  input  logic [XLEN-1:0]       operand_b_i,
  input  logic [TRANS_ID_W-1:0] trans_id_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       result_o,
  output logic [TRANS_ID_W-1:0] trans_id_o,
  output logic                  sat_o,
  output logic                  sat_sticky_o,
  input  logic                  sat_clr_i
);

  localparam int LW  = XLEN / LANES;
  localparam int SHW = $clog2(LW);
  localparam int P   = PIPE_STAGES;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MIN  = 4'd10;
  localparam logic [3:0] OP_MAX  = 4'd11;
  localparam logic [3:0] OP_MINU = 4'd12;
  localparam logic [3:0] OP_MAXU = 4'd13;
  localparam logic [3:0] OP_CPOP = 4'd14;

  // --------------------------------------------------------------------------
  // Combinational lane compute (ahead of stage 1)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  lane_res;
  logic [LANES-1:0] lane_sat;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LW-1:0]  a_l;
      logic [LW-1:0]  b_l;
      logic [LW-1:0]  sum_l;
      logic [LW-1:0]  dif_l;
      logic [LW-1:0]  cnt_l;
      logic [LW-1:0]  clamp_l;
      logic [LW-1:0]  res_l;
      logic [SHW-1:0] sh_l;
      logic           add_ovf_l;
      logic           sub_ovf_l;
      logic           lt_s_l;
      logic           lt_u_l;
      logic           sat_l;

      assign a_l   = operand_a_i[gi*LW +: LW];
      assign b_l   = operand_b_i[gi*LW +: LW];
      assign sh_l  = b_l[SHW-1:0];
      assign sum_l = a_l + b_l;
      assign dif_l = a_l - b_l;

      // Signed overflow can only occur when the operands (for SUB, a and -b)
      // have the same sign and the result's sign differs from a's sign.
      assign add_ovf_l = (a_l[LW-1] == b_l[LW-1]) && (sum_l[LW-1] != a_l[LW-1]);
      assign sub_ovf_l = (a_l[LW-1] != b_l[LW-1]) && (dif_l[LW-1] != a_l[LW-1]);

      // The true result has the same sign as a, so a's sign picks the clamp.
      assign clamp_l = a_l[LW-1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};

      assign lt_s_l = $signed(a_l) < $signed(b_l);
      assign lt_u_l = a_l < b_l;

      always_comb begin
        cnt_l = '0;
        for (int i = 0; i < LW; i++) begin
          cnt_l = cnt_l + {{(LW-1){1'b0}}, a_l[i]};
        end
      end

      always_comb begin
        res_l = '0;
        sat_l = 1'b0;
        case (op_i)
          OP_ADD: begin
            res_l = sum_l;
            if (sat_i && add_ovf_l) begin
              res_l = clamp_l;
              sat_l = 1'b1;
            end
          end
          OP_SUB: begin
            res_l = dif_l;
            if (sat_i && sub_ovf_l) begin
              res_l = clamp_l;
              sat_l = 1'b1;
            end
          end
          OP_AND:  res_l = a_l & b_l;
          OP_OR:   res_l = a_l | b_l;
          OP_XOR:  res_l = a_l ^ b_l;
          OP_SLL:  res_l = a_l << sh_l;
          OP_SRL:  res_l = a_l >> sh_l;
          OP_SRA:  res_l = $signed(a_l) >>> sh_l;
          OP_SLT:  res_l = {{(LW-1){1'b0}}, lt_s_l};
          OP_SLTU: res_l = {{(LW-1){1'b0}}, lt_u_l};
          OP_MIN:  res_l = lt_s_l ? a_l : b_l;
          OP_MAX:  res_l = lt_s_l ? b_l : a_l;
          OP_MINU: res_l = lt_u_l ? a_l : b_l;
          OP_MAXU: res_l = lt_u_l ? b_l : a_l;
          OP_CPOP: res_l = cnt_l;
          default: begin
            res_l = '0;
            sat_l = 1'b0;
          end
        endcase
      end

      assign lane_res[gi*LW +: LW] = res_l;
      assign lane_sat[gi]          = sat_l;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pipeline stages: index 0 holds the compute result, index P-1 drives the
  // outputs.
  // --------------------------------------------------------------------------
  logic [P-1:0]          valid_q, valid_d;
  logic [P-1:0]          satf_q, satf_d;
  logic [XLEN-1:0]       data_q [P];
  logic [XLEN-1:0]       data_d [P];
  logic [TRANS_ID_W-1:0] tid_q  [P];
  logic [TRANS_ID_W-1:0] tid_d  [P];
  logic [P-1:0]          move_c;
  logic [P-1:0]          load_c;
  logic                  sticky_q, sticky_d;

  // move_c[k]: the content of stage k leaves at this edge.
  // load_c[k]: stage k can take new content at this edge, either because it
  // is empty or because its current content is moving on.
  // The chain is evaluated from the output end back to the input.
  always_comb begin
    move_c      = '0;
    move_c[P-1] = valid_q[P-1] & out_ready_i;
    for (int k = P - 2; k >= 0; k--) begin
      move_c[k] = valid_q[k] & (~valid_q[k+1] | move_c[k+1]);
    end
    load_c = ~valid_q | move_c;
  end

  always_comb begin
    valid_d = valid_q;
    satf_d  = satf_q;
    data_d  = data_q;
    tid_d   = tid_q;

    if (load_c[0]) begin
      valid_d[0] = in_valid_i;
      if (in_valid_i) begin
        data_d[0] = lane_res;
        tid_d[0]  = trans_id_i;
        satf_d[0] = |lane_sat;
      end
    end

    for (int k = 1; k < P; k++) begin
      if (load_c[k]) begin
        valid_d[k] = move_c[k-1];
        // Data is only replaced by a real op, so the output stays stable
        // while it is presented and not yet taken.
        if (move_c[k-1]) begin
          data_d[k] = data_q[k-1];
          tid_d[k]  = tid_q[k-1];
          satf_d[k] = satf_q[k-1];
        end
      end
    end

    if (flush_i) begin
      valid_d = '0;
    end
  end

  // A flushed cycle transfers nothing, so it cannot set the sticky flag.
  always_comb begin
    sticky_d = sticky_q;
    if (sat_clr_i) begin
      sticky_d = 1'b0;
    end else if (valid_q[P-1] && out_ready_i && satf_q[P-1] && !flush_i) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      satf_q   <= '0;
      sticky_q <= 1'b0;
      for (int k = 0; k < P; k++) begin
        data_q[k] <= '0;
        tid_q[k]  <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      satf_q   <= satf_d;
      sticky_q <= sticky_d;
      for (int k = 0; k < P; k++) begin
        data_q[k] <= data_d[k];
        tid_q[k]  <= tid_d[k];
      end
    end
  end

  assign in_ready_o   = load_c[0];
  assign out_valid_o  = valid_q[P-1];
  assign result_o     = data_q[P-1];
  assign trans_id_o   = tid_q[P-1];
  assign sat_o        = satf_q[P-1];
  assign sat_sticky_o = sticky_q;

endmodule
